// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and PC-write interlocks,
// data-memory wait handling with timeout-to-error, and stall/flush event counters.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  regScrA_D,
    input  logic [3:0]  regScrB_D,
    input  logic [3:0]  regScrA_E,
    input  logic [3:0]  regScrB_E,
    input  logic [3:0]  regDst_E,
    input  logic        regw_E,
    input  logic        regmem_E,
    input  logic [3:0]  regDst_M,
    input  logic        regw_M,
    input  logic [3:0]  regDst_W,
    input  logic        regw_W,
    input  logic        pcload_D,
    input  logic        pcload_E,
    input  logic        pcload_M,
    input  logic        pcload_W,
    input  logic        branch_E,
    input  logic        mem_req_M,
    input  logic        mem_ack_M,
    input  logic        err_clr,
    output logic [1:0]  fwdA_E,
    output logic [1:0]  fwdB_E,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_W,
    output logic [1:0]  state,
    output logic        err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        ERROR   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [3:0] PC_REG = 4'd15;

    state_t     cur_state, nxt_state;
    logic [7:0] wait_cnt, wait_nxt;
    logic       err_nxt;
    logic       ldstall, ldq, pcpend, freeze;

    // R15 is the PC: its value never comes from the bypass network.
    function automatic logic [1:0] fwd_sel(input logic [3:0] src);
        if (src == PC_REG)                     return 2'b00;
        else if (regw_M && regDst_M == src)    return 2'b10;
        else if (regw_W && regDst_W == src)    return 2'b01;
        else                                   return 2'b00;
    endfunction

    assign ldstall = regw_E && regmem_E && (regDst_E != PC_REG) &&
                     ((regDst_E == regScrA_D) || (regDst_E == regScrB_D));
    assign ldq     = ldstall && !branch_E;
    assign pcpend  = pcload_D || pcload_E || pcload_M;
    assign freeze  = (cur_state == ERROR) || (mem_req_M && !mem_ack_M);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nxt_state = cur_state;
        wait_nxt  = wait_cnt;
        err_nxt   = err;
        case (cur_state)
            RUN: begin
                if (mem_req_M && !mem_ack_M) begin
                    nxt_state = MEMWAIT;
                    wait_nxt  = 8'd0;
                end
            end
            MEMWAIT: begin
                if (mem_ack_M || !mem_req_M) begin
                    nxt_state = RUN;
                end else if (wait_cnt == 8'd255) begin
                    nxt_state = ERROR;
                    err_nxt   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            ERROR: begin
                if (err_clr) begin
                    nxt_state = RUN;
                    err_nxt   = 1'b0;
                end
            end
            default: nxt_state = RUN;
        endcase
    end

    always_comb begin
        fwdA_E  = 2'b00;
        fwdB_E  = 2'b00;
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b1;
        flush_E = 1'b1;
        flush_W = 1'b1;
        if (!rst) begin
            fwdA_E = fwd_sel(regScrA_E);
            fwdB_E = fwd_sel(regScrB_E);
            if (freeze) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_D = 1'b0;
                flush_E = 1'b0;
                flush_W = 1'b1;
            end else begin
                stall_F = ldq || pcpend;
                stall_D = ldq;
                flush_D = pcpend || pcload_W || branch_E;
                flush_E = ldq || branch_E;
                flush_W = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= RUN;
            wait_cnt  <= 8'd0;
            err       <= 1'b0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_nxt;
            err       <= err_nxt;
            if (stall_F && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if ((flush_D || flush_E) && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random stimulus,
// all compared against a cycle-level behavioural model of the controller.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  regScrA_D, regScrB_D, regScrA_E, regScrB_E;
    logic [3:0]  regDst_E, regDst_M, regDst_W;
    logic        regw_E, regmem_E, regw_M, regw_W;
    logic        pcload_D, pcload_E, pcload_M, pcload_W;
    logic        branch_E, mem_req_M, mem_ack_M, err_clr;
    logic [1:0]  fwdA_E, fwdB_E, state;
    logic        stall_F, stall_D, stall_E, stall_M;
    logic        flush_D, flush_E, flush_W, err;
    logic [15:0] stall_cnt, flush_cnt;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .regScrA_D(regScrA_D), .regScrB_D(regScrB_D),
        .regScrA_E(regScrA_E), .regScrB_E(regScrB_E),
        .regDst_E(regDst_E), .regw_E(regw_E), .regmem_E(regmem_E),
        .regDst_M(regDst_M), .regw_M(regw_M),
        .regDst_W(regDst_W), .regw_W(regw_W),
        .pcload_D(pcload_D), .pcload_E(pcload_E), .pcload_M(pcload_M), .pcload_W(pcload_W),
        .branch_E(branch_E), .mem_req_M(mem_req_M), .mem_ack_M(mem_ack_M), .err_clr(err_clr),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .state(state), .err(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: in_error, waiting + cycles waited so far, saturating event counts.
    bit m_err, m_wait;
    int m_wcnt, m_scnt, m_fcnt;

    function automatic logic [1:0] m_fwd(input logic [3:0] src);
        if (rst || src == 4'd15) return 2'b00;
        if (regw_M && regDst_M == src) return 2'b10;
        if (regw_W && regDst_W == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_ldq();
        bit hit;
        hit = regw_E && regmem_E && regDst_E != 4'd15 &&
              (regDst_E == regScrA_D || regDst_E == regScrB_D);
        return hit && !branch_E;
    endfunction

    function automatic bit m_freeze();
        return m_err || (mem_req_M && !mem_ack_M);
    endfunction

    // {stall_F, stall_D, stall_E, stall_M}
    function automatic logic [3:0] m_stalls();
        bit pcp;
        pcp = pcload_D || pcload_E || pcload_M;
        if (rst)        return 4'b0000;
        if (m_freeze()) return 4'b1111;
        return {m_ldq() || pcp, m_ldq(), 2'b00};
    endfunction

    // {flush_D, flush_E, flush_W}
    function automatic logic [2:0] m_flushes();
        bit pcp;
        pcp = pcload_D || pcload_E || pcload_M;
        if (rst)        return 3'b111;
        if (m_freeze()) return 3'b001;
        return {pcp || pcload_W || branch_E, m_ldq() || branch_E, 1'b0};
    endfunction

    function automatic logic [1:0] m_state();
        return m_err ? 2'b10 : (m_wait ? 2'b01 : 2'b00);
    endfunction

    task automatic model_reset();
        m_err = 0; m_wait = 0; m_wcnt = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_edge();
        logic [3:0] s;
        logic [2:0] f;
        if (rst) return;
        s = m_stalls();
        f = m_flushes();
        if (s[3] && m_scnt < 65535) m_scnt++;
        if ((f[2] || f[1]) && m_fcnt < 65535) m_fcnt++;
        if (m_err) begin
            if (err_clr) m_err = 0;
        end else if (m_wait) begin
            if (mem_ack_M || !mem_req_M) m_wait = 0;
            else if (m_wcnt == 255) begin m_wait = 0; m_err = 1; end
            else m_wcnt++;
        end else if (mem_req_M && !mem_ack_M) begin
            m_wait = 1;
            m_wcnt = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("fwdA", fwdA_E, m_fwd(regScrA_E));
        chk("fwdB", fwdB_E, m_fwd(regScrB_E));
        chk("stalls", {stall_F, stall_D, stall_E, stall_M}, m_stalls());
        chk("flushes", {flush_D, flush_E, flush_W}, m_flushes());
        chk("state", state, m_state());
        chk("err", err, m_err);
        chk("stall_cnt", stall_cnt, m_scnt);
        chk("flush_cnt", flush_cnt, m_fcnt);
    endtask

    // Compare just before the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        {regScrA_D, regScrB_D, regScrA_E, regScrB_E} = '0;
        {regDst_E, regDst_M, regDst_W} = '0;
        {regw_E, regmem_E, regw_M, regw_W} = '0;
        {pcload_D, pcload_E, pcload_M, pcload_W} = '0;
        {branch_E, mem_req_M, mem_ack_M, err_clr} = '0;
    endtask

    function automatic logic [3:0] rnd_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        int s0, n;
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        chk("rst_state", state, 2'b00);
        chk("rst_flushes", {flush_D, flush_E, flush_W}, 3'b111);
        chk("rst_stalls", {stall_F, stall_D, stall_E, stall_M}, 4'b0000);
        cycle();
        cycle();
        rst = 1'b0;

        // Forwarding priority and PC exclusion
        regw_M = 1; regw_W = 1; regDst_M = 3; regDst_W = 3; regScrA_E = 3;
        #1 chk("fwd_m", fwdA_E, 2'b10);
        cycle();
        regw_M = 0;
        #1 chk("fwd_w", fwdA_E, 2'b01);
        cycle();
        regw_M = 1; regDst_M = 15; regDst_W = 15; regScrA_E = 15; regScrB_E = 15;
        #1 chk("fwd_pc", {fwdA_E, fwdB_E}, 4'b0000);
        cycle();
        clear_inputs();

        // Load-use interlock, then cancelled by a taken branch
        regw_E = 1; regmem_E = 1; regDst_E = 4; regScrB_D = 4; regScrA_D = 7;
        #1 chk("ld_stall", {stall_F, stall_D, flush_E}, 3'b111);
        s0 = m_scnt;
        cycle();
        chk("ld_cnt", stall_cnt, s0 + 1);
        branch_E = 1;
        #1 chk("ld_branch", {stall_D, flush_D, flush_E}, 3'b011);
        cycle();
        regDst_E = 15; regScrA_D = 15; branch_E = 0;
        #1 chk("ld_pc", {stall_F, stall_D}, 2'b00);
        cycle();
        clear_inputs();

        // PC-writing instruction walking down the pipe
        for (int i = 0; i < 4; i++) begin
            {pcload_D, pcload_E, pcload_M, pcload_W} = 4'b1000 >> i;
            #1 chk("pc_walk", {stall_F, flush_D}, (i < 3) ? 2'b11 : 2'b01);
            cycle();
        end
        clear_inputs();

        // Memory wait of three cycles
        s0 = m_scnt;
        mem_req_M = 1;
        for (int i = 0; i < 4; i++) begin
            mem_ack_M = (i == 3);
            #1 chk("mw_state", state, (i == 0) ? 2'b00 : 2'b01);
            chk("mw_ctl", {stall_F, stall_D, stall_E, stall_M, flush_W},
                (i == 3) ? 5'b00000 : 5'b11111);
            cycle();
        end
        chk("mw_run", state, 2'b00);
        chk("mw_cnt", stall_cnt, s0 + 3);
        clear_inputs();

        // Timeout into ERROR, err_clr ignored until then
        mem_req_M = 1; err_clr = 1;
        cycle();
        err_clr = 0;
        n = 0;
        while (state === 2'b01 && n < 300) begin
            cycle();
            n++;
        end
        chk("to_len", n, 256);
        chk("to_err", {state, err}, 3'b101);
        mem_req_M = 0;
        cycle();
        #1 chk("to_hold", {state, stall_F, stall_M, flush_W}, 5'b10111);
        err_clr = 1;
        cycle();
        chk("to_clr", {state, err}, 3'b000);
        clear_inputs();

        // Asynchronous reset in the middle of a memory wait
        mem_req_M = 1;
        cycle();
        cycle();
        #2 rst = 1;
        #1;
        model_reset();
        chk("ar_state", state, 2'b00);
        chk("ar_cnts", {stall_cnt, flush_cnt}, 32'h0);
        chk("ar_flush", {flush_D, flush_E, flush_W}, 3'b111);
        cycle();
        rst = 0;
        clear_inputs();

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            regScrA_D = rnd_reg(); regScrB_D = rnd_reg();
            regScrA_E = rnd_reg(); regScrB_E = rnd_reg();
            regDst_E  = rnd_reg(); regDst_M  = rnd_reg(); regDst_W = rnd_reg();
            {regw_E, regmem_E, regw_M, regw_W} = 4'($urandom);
            pcload_D = ($urandom_range(0, 5) == 0);
            pcload_E = ($urandom_range(0, 5) == 0);
            pcload_M = ($urandom_range(0, 5) == 0);
            pcload_W = ($urandom_range(0, 5) == 0);
            branch_E = ($urandom_range(0, 4) == 0);
            if (i >= 600 && i < 900) begin
                mem_req_M = 1; mem_ack_M = 0;
            end else begin
                mem_req_M = ($urandom_range(0, 2) == 0);
                mem_ack_M = ($urandom_range(0, 2) != 0);
            end
            err_clr = (i >= 600 && i < 900) ? 1'b0 : ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
